// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and burst-size helpers for the multiplier host.
//   host_state_t  : transaction sequencer states of mult_host
//   mult_state_t  : state encoding of the attached multiplier, kept here so
//                   host and multiplier agree on one definition
//   depth_of()    : burst depth for a given log2 depth
//   tmo_limit_of(): cycles allowed from WAIT_FULL entry until a forced DONE
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int LOGDEPTH_DEF = 6;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FEED      = 3'd1,
      S_WAIT_FULL = 3'd2,
      S_REQ       = 3'd3,
      S_COLLECT   = 3'd4,
      S_DONE      = 3'd5
   } host_state_t;

   typedef enum logic [1:0] {
      M_IDLE    = 2'd0,
      M_LOAD    = 2'd1,
      M_COMPUTE = 2'd2,
      M_READ    = 2'd3
   } mult_state_t;

   function automatic int depth_of(input int logdepth);
      return 1 << logdepth;
   endfunction

   // The multiplier gets four burst lengths to fill and stream back.
   function automatic int tmo_limit_of(input int logdepth);
      return 4 * depth_of(logdepth);
   endfunction

endpackage

// File: rtl/mult_acc.sv
// ---------------------------------------------------------------------------
// mult_acc
// Clear/enable accumulator for readback beats.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clr_i    : zero sum and beat count (wins over en_i)
//   en_i     : add data_i to the sum and count one beat
//   data_i   : readback beat, zero-extended into the sum
//   sum_o    : running sum, LOGDEPTH guard bits so DEPTH max beats fit
//   beats_o  : number of beats accumulated since the last clear
// ---------------------------------------------------------------------------
module mult_acc
   import mult_pkg::*;
#(
   parameter int LOGDEPTH = LOGDEPTH_DEF,
   parameter int WIDTH    = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clr_i,
   input  logic                      en_i,
   input  logic [WIDTH-1:0]          data_i,
   output logic [WIDTH+LOGDEPTH-1:0] sum_o,
   output logic [LOGDEPTH:0]         beats_o
);

   logic [WIDTH+LOGDEPTH-1:0] sum_q;
   logic [LOGDEPTH:0]         beats_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q   <= '0;
         beats_q <= '0;
      end else if (clr_i) begin
         sum_q   <= '0;
         beats_q <= '0;
      end else if (en_i) begin
         sum_q   <= sum_q + {{LOGDEPTH{1'b0}}, data_i};
         beats_q <= beats_q + (LOGDEPTH+1)'(1);
      end
   end

   assign sum_o   = sum_q;
   assign beats_o = beats_q;

endmodule

// File: rtl/mult_host.sv
// ---------------------------------------------------------------------------
// mult_host
// Sequences one multiplier transaction: streams DEPTH operand pairs into the
// multiplier, waits for it to finish, requests a block readback and sums the
// returned beats.
//   clk, rst                  : clock; asynchronous active-low reset
//   start                     : begin a transaction (only looked at in IDLE)
//   op_valid/op_ready,op_a/b  : upstream operand handshake
//   EN_mult, mult_input0/1    : operand feed to the multiplier
//   RDY_mult                  : multiplier ready; low means burst computed
//   EN_blockRead              : one-cycle readback request
//   VALID_memVal, memVal_data : readback beats
//   sum_valid                 : one-cycle pulse, results below are valid
//   sum_data, beats           : accumulated sum and beat count
//   underrun, timeout         : sticky error flags of the last transaction
//   busy                      : high outside IDLE
// ---------------------------------------------------------------------------
module mult_host
   import mult_pkg::*;
#(
   parameter int LOGDEPTH = LOGDEPTH_DEF,
   parameter int WIDTH    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  logic [15:0]               op_a,
   input  logic [15:0]               op_b,
   output logic                      EN_mult,
   output logic [15:0]               mult_input0,
   output logic [15:0]               mult_input1,
   input  logic                      RDY_mult,
   output logic                      EN_blockRead,
   input  logic                      VALID_memVal,
   input  logic [WIDTH-1:0]          memVal_data,
   output logic                      sum_valid,
   output logic [WIDTH+LOGDEPTH-1:0] sum_data,
   output logic [LOGDEPTH:0]         beats,
   output logic                      underrun,
   output logic                      timeout,
   output logic                      busy
);

   localparam int DEPTH     = depth_of(LOGDEPTH);
   localparam int TMO_LIMIT = tmo_limit_of(LOGDEPTH);
   localparam int TW        = LOGDEPTH + 3;

   localparam logic [LOGDEPTH-1:0] FEED_LAST  = LOGDEPTH'(DEPTH - 1);
   localparam logic [TW-1:0]       TMO_LAST   = TW'(TMO_LIMIT - 1);
   localparam logic [LOGDEPTH:0]   BEATS_LAST = (LOGDEPTH+1)'(DEPTH - 1);

   host_state_t         state_q;
   logic [LOGDEPTH-1:0] feed_cnt_q;
   logic [TW-1:0]       tmo_cnt_q;
   logic                underrun_q;
   logic                timeout_q;
   logic                op_ready_q;
   logic                en_mult_q;
   logic                en_blockread_q;
   logic                sum_valid_q;
   logic                busy_q;

   logic start_d;
   logic acc_en_d;
   logic last_beat_d;
   logic tmo_hit_d;

   assign start_d  = (state_q == S_IDLE) && start && RDY_mult;
   assign acc_en_d = (state_q == S_COLLECT) && VALID_memVal;
   // This cycle's beat brings the count to DEPTH.
   assign last_beat_d = acc_en_d && (beats == BEATS_LAST);
   // Counter holds k-1 during the k-th cycle after WAIT_FULL entry.
   assign tmo_hit_d = (tmo_cnt_q == TMO_LAST);

   mult_acc #(
      .LOGDEPTH (LOGDEPTH),
      .WIDTH    (WIDTH)
   ) u_acc (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (start_d),
      .en_i    (acc_en_d),
      .data_i  (memVal_data),
      .sum_o   (sum_data),
      .beats_o (beats)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         feed_cnt_q     <= '0;
         tmo_cnt_q      <= '0;
         underrun_q     <= 1'b0;
         timeout_q      <= 1'b0;
         op_ready_q     <= 1'b0;
         en_mult_q      <= 1'b0;
         en_blockread_q <= 1'b0;
         sum_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_d) begin
                  state_q    <= S_FEED;
                  feed_cnt_q <= '0;
                  tmo_cnt_q  <= '0;
                  underrun_q <= 1'b0;
                  timeout_q  <= 1'b0;
                  op_ready_q <= 1'b1;
                  en_mult_q  <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end

            S_FEED: begin
               en_mult_q <= 1'b0;
               // A missing operand still consumes a feed slot; zeros go out.
               if (!op_valid) begin
                  underrun_q <= 1'b1;
               end
               if (feed_cnt_q == FEED_LAST) begin
                  state_q    <= S_WAIT_FULL;
                  op_ready_q <= 1'b0;
                  tmo_cnt_q  <= '0;
               end else begin
                  feed_cnt_q <= feed_cnt_q + LOGDEPTH'(1);
               end
            end

            S_WAIT_FULL: begin
               tmo_cnt_q <= tmo_cnt_q + TW'(1);
               if (tmo_hit_d) begin
                  state_q     <= S_DONE;
                  timeout_q   <= 1'b1;
                  sum_valid_q <= 1'b1;
               end else if (!RDY_mult) begin
                  state_q        <= S_REQ;
                  en_blockread_q <= 1'b1;
               end
            end

            S_REQ: begin
               tmo_cnt_q      <= tmo_cnt_q + TW'(1);
               en_blockread_q <= 1'b0;
               if (tmo_hit_d) begin
                  state_q     <= S_DONE;
                  timeout_q   <= 1'b1;
                  sum_valid_q <= 1'b1;
               end else begin
                  state_q <= S_COLLECT;
               end
            end

            S_COLLECT: begin
               tmo_cnt_q <= tmo_cnt_q + TW'(1);
               // A beat arriving on the expiry cycle is still summed by the
               // accumulator; the flag just records that time ran out.
               if (tmo_hit_d || last_beat_d ||
                   (!VALID_memVal && (beats != '0))) begin
                  state_q     <= S_DONE;
                  sum_valid_q <= 1'b1;
                  if (tmo_hit_d) begin
                     timeout_q <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               state_q     <= S_IDLE;
               sum_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Operands pass straight through only while feeding.
   assign mult_input0 = ((state_q == S_FEED) && op_valid) ? op_a : 16'h0000;
   assign mult_input1 = ((state_q == S_FEED) && op_valid) ? op_b : 16'h0000;

   assign op_ready     = op_ready_q;
   assign EN_mult      = en_mult_q;
   assign EN_blockRead = en_blockread_q;
   assign sum_valid    = sum_valid_q;
   assign underrun     = underrun_q;
   assign timeout      = timeout_q;
   assign busy         = busy_q;

endmodule

// File: doc/mult_host.md
MULT_HOST -- requirements
Module: mult_host

Interface
REQ-001 Parameters (name, default, meaning): LOGDEPTH, 6, log2 of burst depth (DEPTH = 2**LOGDEPTH); WIDTH, 32, product/readback data width.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request one feed/collect transaction; sampled only in IDLE.
REQ-005 op_valid / op_ready  in / out  1 / 1  upstream operand handshake; transfer when both high.
REQ-006 op_a, op_b  in  16 each  upstream operands.
REQ-007 EN_mult  out  1  start pulse to multiplier.
REQ-008 mult_input0, mult_input1  out  16 each  operands to multiplier.
REQ-009 RDY_mult  in  1  multiplier ready/accepting operands.
REQ-010 EN_blockRead  out  1  block-readback request to multiplier.
REQ-011 VALID_memVal  in  1  readback beat valid.
REQ-012 memVal_data  in  WIDTH  readback beat data.
REQ-013 sum_valid  out  1  one-cycle pulse, sum_data/beats/flags valid.
REQ-014 sum_data  out  WIDTH+LOGDEPTH  accumulated sum of readback beats.
REQ-015 beats  out  LOGDEPTH+1  number of readback beats accumulated.
REQ-016 underrun, timeout  out  1 each  sticky error flags for the last transaction.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, FEED, WAIT_FULL, REQ, COLLECT, DONE.
REQ-019 IDLE -> FEED when start=1 and RDY_mult=1; otherwise stay; start while busy is ignored.
REQ-020 FEED lasts exactly DEPTH cycles; EN_mult=1 in first FEED cycle only; op_ready=1 in every FEED cycle, 0 elsewhere.
REQ-021 In each FEED cycle mult_input0/1 = op_a/op_b combinationally when op_valid=1; else both 0 and underrun set; feed counter advances regardless.
REQ-022 Outside FEED, mult_input0/1 = 0.
REQ-023 FEED -> WAIT_FULL after the DEPTH-th cycle; WAIT_FULL -> REQ when RDY_mult=0.
REQ-024 REQ: EN_blockRead=1 for exactly one cycle, then COLLECT.
REQ-025 COLLECT: each cycle with VALID_memVal=1 adds zero-extended memVal_data to sum_data and increments beats.
REQ-026 COLLECT -> DONE when beats reaches DEPTH, or VALID_memVal=0 after at least one beat accumulated.
REQ-027 Timeout counter starts at 0 on entry to WAIT_FULL, increments each cycle in WAIT_FULL/REQ/COLLECT; at 4*DEPTH cycles -> DONE with timeout=1.
REQ-028 DONE: sum_valid=1 for one cycle, then IDLE; sum_data, beats, underrun, timeout hold until next FEED entry.
REQ-029 On FEED entry: sum_data, beats, underrun, timeout, counters cleared to 0.
REQ-030 Sum width WIDTH+LOGDEPTH; no overflow for DEPTH beats of max value.
REQ-031 Simultaneous VALID_memVal and timeout expiry: beat is accumulated, then DONE.

Reset
REQ-032 rst=0 asynchronously forces IDLE and all outputs/registers 0 (op_ready, EN_mult, EN_blockRead, sum_valid, busy, flags, sum_data, beats, mult_inputs).
REQ-033 Reset mid-transaction abandons it; no sum_valid is produced; first start after release begins a fresh transaction.

Structure
REQ-034 Package mult_pkg holds host_state_t enum and DEPTH-derived constants (DEPTH, timeout limit); multiplier state enum moves into the same package.
REQ-035 One sub-module mult_acc: clear/enable accumulator producing sum_data and beats.

Verification
REQ-036 op_a=op_b=1 all 64 cycles, readback 64 beats of 1 -> EN_mult one pulse, op_ready high 64 cycles, sum_data=64, beats=64, flags 0.
REQ-037 op_a=op_b=0xFFFF, 64 beats of 0xFFFE0001 -> sum_data=0x3FFF800040, beats=64.
REQ-038 op_valid low on FEED cycle 10 -> inputs 0 that cycle, underrun=1, FEED still 64 cycles.
REQ-039 63 readback beats of 2 then VALID low -> sum_data=126, beats=63, timeout=0.
REQ-040 RDY_mult stays 1 after FEED -> DONE after 256 cycles, timeout=1, beats=0.
REQ-041 rst low during COLLECT beat 20 -> all outputs 0 immediately, no sum_valid; next start runs normally.
